// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: the FSM state encoding
// and the register-index width used by the hazard compare logic.
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus. The master is the pipeline datapath, which drives
// the hazard sources. The slave is the controller, which drives the enables and flushes.
interface pipe_hazard_ctrl_if;
  import hazard_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic [REG_IDX_W-1:0] idex_rd;
  logic                 idex_lw;
  logic                 exmem_branch_taken;
  logic                 exmem_jump;
  logic                 exmem_jalr;
  logic                 exmem_lw;
  logic                 exmem_sw;
  logic                 mem_ready;

  logic                 pc_en;
  logic                 ifid_en;
  logic                 idex_en;
  logic                 exmem_en;
  logic                 memwb_en;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 exmem_flush;
  logic                 pc_redirect;
  logic                 mem_valid;
  logic                 mem_err;
  logic [31:0]          stall_cnt;

  modport master (
    output id_rs1, id_rs2, idex_rd, idex_lw,
           exmem_branch_taken, exmem_jump, exmem_jalr,
           exmem_lw, exmem_sw, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush,
           pc_redirect, mem_valid, mem_err, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, idex_rd, idex_lw,
           exmem_branch_taken, exmem_jump, exmem_jalr,
           exmem_lw, exmem_sw, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush,
           pc_redirect, mem_valid, mem_err, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Saturating 32-bit stall-cycle counter. It is instantiated by
// pipe_hazard_ctrl only when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_inc)
      r_cnt <= sat_inc(r_cnt);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM, redirect flushes, and load-use bubbles.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  hz_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_nxt;

  logic w_mem_req, w_redirect, w_load_use;
  logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic w_ifid_flush, w_idex_flush, w_exmem_flush;
  logic w_pc_redirect, w_mem_valid;

  assign w_mem_req  = bus.exmem_lw | bus.exmem_sw;
  assign w_redirect = bus.exmem_branch_taken | bus.exmem_jump | bus.exmem_jalr;
  // A load into x0 never creates a dependency.
  assign w_load_use = bus.idex_lw && (bus.idex_rd != '0) &&
                      ((bus.idex_rd == bus.id_rs1) || (bus.idex_rd == bus.id_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_idex_en     = 1'b1;
    w_exmem_en    = 1'b1;
    w_memwb_en    = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_pc_redirect = 1'b0;
    w_mem_valid   = 1'b0;

    if (!reset) begin
      case (r_state)
        RUN: begin
          w_mem_valid = w_mem_req;
          if (w_mem_req && !bus.mem_ready) begin
            {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '0;
            w_state_nxt = MEM_WAIT;
            w_wait_nxt  = CNT_W'(1);
          end else if (w_redirect) begin
            w_pc_redirect = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
          end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
          end
        end

        // Redirects and load-use are deferred until the pipeline is back in RUN.
        MEM_WAIT: begin
          w_mem_valid = 1'b1;
          if (bus.mem_ready) begin
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
          end else begin
            {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '0;
            if (r_wait_cnt == TIMEOUT_C)
              w_state_nxt = ERROR;
            else
              w_wait_nxt = r_wait_cnt + CNT_W'(1);
          end
        end

        ERROR: begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '0;
        end

        default: begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end
      endcase
    end
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.ifid_en     = w_ifid_en;
  assign bus.idex_en     = w_idex_en;
  assign bus.exmem_en    = w_exmem_en;
  assign bus.memwb_en    = w_memwb_en;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.exmem_flush = w_exmem_flush;
  assign bus.pc_redirect = w_pc_redirect;
  assign bus.mem_valid   = w_mem_valid;
  assign bus.mem_err     = (r_state == ERROR);

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (~w_pc_en),
    .o_cnt (bus.stall_cnt)
  );
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 16, the maximum number of data-memory wait cycles before an error is declared.
REQ-002 SHALL provide: clk  in  1  clock; all state updates on posedge clk.
REQ-003 SHALL provide: reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL provide: id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-005 SHALL provide: idex_rd  in  5  destination register of the instruction in EX; idex_lw  in  1  EX instruction is a load.
REQ-006 SHALL provide: exmem_branch_taken, exmem_jump, exmem_jalr  in  1 each  control-transfer resolved in the EX/MEM stage.
REQ-007 SHALL provide: exmem_lw, exmem_sw  in  1 each  data-memory access pending in the EX/MEM stage; mem_ready  in  1  memory completion.
REQ-008 SHALL provide: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  per-stage advance enables.
REQ-009 SHALL provide: ifid_flush, idex_flush, exmem_flush  out  1 each  insert a bubble into that pipeline register.
REQ-010 SHALL provide: pc_redirect  out  1  select the branch/jump target for the PC; mem_valid  out  1  memory request strobe.
REQ-011 SHALL provide: mem_err  out  1  sticky timeout flag; stall_cnt  out  32  stall-cycle counter.

Function
REQ-012 SHALL implement the FSM states RUN, MEM_WAIT, and ERROR.
REQ-013 SHALL, in RUN, assert mem_valid combinationally whenever exmem_lw or exmem_sw is set.
  - If mem_ready is also set, the pipeline advances.
  - If mem_ready is clear, the next state is MEM_WAIT and the wait counter loads 1.
REQ-014 SHALL, in the cycle a memory access is not ready and throughout MEM_WAIT, hold all five enables at 0, hold all flushes at 0, and keep mem_valid at 1.
REQ-015 SHALL, in MEM_WAIT, leave to RUN on mem_ready=1 with all enables at 1 in that same cycle; otherwise the wait counter increments.
REQ-016 SHALL transition MEM_WAIT -> ERROR when the wait counter equals MEM_TIMEOUT and mem_ready=0.
REQ-017 SHALL, in ERROR, hold all enables at 0, all flushes at 0, mem_valid at 0, and mem_err at 1 until reset.
REQ-018 SHALL, in RUN when redirect = exmem_branch_taken|exmem_jump|exmem_jalr, assert pc_redirect, ifid_flush, idex_flush, and exmem_flush in the same cycle, with all enables at 1.
REQ-019 SHALL detect a load-use hazard when idex_lw=1, idex_rd!=0, and idex_rd equals id_rs1 or id_rs2.
REQ-020 SHALL, in RUN with a load-use hazard and no redirect, set pc_en=0, ifid_en=0, and idex_flush=1 for exactly one cycle, with exmem_en and memwb_en at 1.
REQ-021 SHALL apply the priority ERROR > memory stall > redirect > load-use; a load-use hazard during a memory stall is re-evaluated after resume.
REQ-022 SHALL, in the absence of any event, drive all enables at 1, all flushes at 0, pc_redirect at 0, and mem_valid at 0.
REQ-023 SHALL keep the wait counter at clog2(MEM_TIMEOUT+1) bits; the counter is never reached beyond MEM_TIMEOUT.

Reset
REQ-024 SHALL, on reset, force state to RUN, clear the wait counter, clear mem_err, and clear stall_cnt, regardless of the current state (including mid-MEM_WAIT and ERROR).
REQ-025 SHALL, while reset is asserted, drive the outputs to the RUN/no-event values of REQ-022.

Configuration
REQ-026 SHALL, with HAZARD_PERF_CNT_EN defined, increment stall_cnt by 1 each cycle that pc_en=0 and reset is low, saturating at 32'hFFFF_FFFF.
REQ-027 SHALL, without HAZARD_PERF_CNT_EN, tie stall_cnt to 0 and infer no counter flops.

Structure
REQ-028 SHALL place the FSM state enum (RUN, MEM_WAIT, ERROR) and the register-index width constant (5) in the shared package hazard_pkg.
REQ-029 SHALL implement the saturating counter as the sub-module hazard_perf_cnt, instantiated only under HAZARD_PERF_CNT_EN; all other logic is flat.

Verification
REQ-030 SHALL verify the load-use hazard:
  - Stimulus: idex_lw=1, idex_rd=5, id_rs2=5.
  - Response: one cycle of pc_en=0, ifid_en=0, idex_flush=1, then all enables return to 1.
REQ-031 SHALL verify the x0 exclusion:
  - Stimulus: idex_lw=1, idex_rd=0, id_rs1=0.
  - Response: no stall.
REQ-032 SHALL verify the redirect-over-load-use priority:
  - Stimulus: exmem_branch_taken=1 together with a load-use hazard.
  - Response: pc_redirect=1 and all three flushes =1, pc_en=1, no bubble.
REQ-033 SHALL verify a delayed memory completion:
  - Stimulus: exmem_lw=1, mem_ready asserted 3 cycles later.
  - Response: enables at 0 for 3 cycles, mem_valid=1 throughout, resume on the 4th cycle; with the macro, stall_cnt=3.
REQ-034 SHALL verify the timeout:
  - Stimulus: exmem_sw=1, MEM_TIMEOUT=4, mem_ready never asserted.
  - Response: ERROR is entered after 4 wait cycles, mem_err=1, and it stays set.
REQ-035 SHALL verify reset from ERROR:
  - Stimulus: reset pulse while in ERROR.
  - Response: state=RUN, mem_err=0, stall_cnt=0, all enables=1 in the first cycle after reset deasserts.
